sub_define_pipe: RTL and testbench

SUB_DEFINE_PIPE -- requirements
Module: sub_define_pipe

---
 rtl/sub_define_pkg.sv | 25 ++
 rtl/sub_define_fifo2.sv | 89 ++++++++
 rtl/sub_define_pipe.sv | 76 +++++++
 tb/tb_sub_define_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_define_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_define_pkg
//  Description : Shared types and defaults for the sub_define decode pipe.
//  Revision    : 1.0
// ============================================================================
package sub_define_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_dec   = 2;
    localparam int c_count_width   = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_state_t;

    // The FIFO can take another word in any state except FULL.
    function automatic logic accepts_push(input fill_state_t state);
        return (state != FULL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_define_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : sub_define_fifo2
//  Description : Two-entry FIFO with a registered write-ready, no ready path.
//  Revision    : 1.0
// ============================================================================
module sub_define_fifo2
    import sub_define_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    fill_state_t      r_state;
    fill_state_t      w_state_next;
    logic             r_ready;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign w_push = wr_valid && r_ready;
    assign w_pop  = (r_state != EMPTY) && rd_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_push) w_state_next = ONE;
            end
            ONE: begin
                if (w_push && !w_pop)      w_state_next = FULL;
                else if (w_pop && !w_push) w_state_next = EMPTY;
            end
            FULL: begin
                if (w_pop) w_state_next = ONE;
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // Ready is computed from the next state so it is purely registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= accepts_push(w_state_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) r_head <= wr_data;
                end
                ONE: begin
                    if (w_push && w_pop) r_head <= wr_data;
                    else if (w_push)     r_tail <= wr_data;
                end
                FULL: begin
                    if (w_pop) r_head <= r_tail;
                end
                default: begin
                    r_head <= r_head;
                end
            endcase
        end
    end

    assign wr_ready = r_ready;
    assign rd_valid = (r_state != EMPTY);
    assign rd_data  = r_head;

endmodule
`default_nettype wire

// File: rtl/sub_define_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sub_define_pipe
//  Description : Subtracts DEC from each word, buffers in a 2-entry FIFO,
//                tracks sticky underflow and a wrapping transfer count.
//                Define SUB_DEFINE_SATURATE_EN to clamp underflowing words to 0.
//  Revision    : 1.0
// ============================================================================
module sub_define_pipe
    import sub_define_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEC   = c_default_dec
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     underflow,
    output logic [c_count_width-1:0] out_count
);

    localparam logic [WIDTH-1:0] c_dec = WIDTH'(DEC);

    logic                     w_below;
    logic [WIDTH-1:0]         w_diff;
    logic [WIDTH-1:0]         w_decoded;
    logic                     w_push;
    logic                     w_pop;
    logic                     r_underflow;
    logic [c_count_width-1:0] r_count;

    assign w_below = (in_data < c_dec);
    assign w_diff  = in_data - c_dec;

`ifdef SUB_DEFINE_SATURATE_EN
    assign w_decoded = w_below ? '0 : w_diff;
`else
    assign w_decoded = w_diff;
`endif

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    sub_define_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (in_valid),
        .wr_data  (w_decoded),
        .wr_ready (in_ready),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_push && w_below) r_underflow <= 1'b1;
            if (w_pop)             r_count     <= r_count + 1'b1;
        end
    end

    assign underflow = r_underflow;
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sub_define_pipe.sv
`default_nettype none
// Bench for sub_define_pipe: fixed vector table, reset/wrap sequences and
// random traffic compared against a queue-based model.
module tb_sub_define_pipe;

    localparam int WIDTH = 16;
    localparam int DEC   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             underflow;
    logic [15:0]      out_count;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] m_q[$];
    logic             m_ready;
    logic             m_uf;
    logic [15:0]      m_count;

    always #5 clk = ~clk;

    sub_define_pipe #(.WIDTH(WIDTH), .DEC(DEC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .underflow (underflow),
        .out_count (out_count)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_ready;
        logic        e_uf;
        logic [15:0] e_count;
    } vec_t;

    function automatic logic [WIDTH-1:0] decode(input logic [WIDTH-1:0] d);
`ifdef SUB_DEFINE_SATURATE_EN
        if (d < DEC) return '0;
`endif
        return WIDTH'(d - DEC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0;
        m_uf    = 1'b0;
        m_count = '0;
    endtask

    task automatic check_model();
        chk("model_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("model_in_ready", 32'(in_ready), 32'(m_ready));
        chk("model_underflow", 32'(underflow), 32'(m_uf));
        chk("model_out_count", 32'(out_count), 32'(m_count));
        if (m_q.size() > 0) chk("model_out_data", 32'(out_data), 32'(m_q[0]));
    endtask

    // One clock: drive at negedge, update model at posedge, compare at negedge.
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        logic push, pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        push = v && m_ready;
        pop  = (m_q.size() > 0) && r;
        @(posedge clk);
        if (pop) begin
            void'(m_q.pop_front());
            m_count = m_count + 16'd1;
        end
        if (push) begin
            m_q.push_back(decode(d));
            if (d < DEC) m_uf = 1'b1;
        end
        m_ready = (m_q.size() < 2);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("ready_low_after_release", 32'(in_ready), 32'd0);
        step(1'b0, 16'd0, 1'b0);
    endtask

    vec_t tbl[14];

    initial begin
`ifdef SUB_DEFINE_SATURATE_EN
        logic [15:0] uf_word = 16'h0000;
`else
        logic [15:0] uf_word = 16'hFFFF;
`endif
        tbl[0]  = '{1'b1, 16'd14, 1'b1, 1'b1, 16'd12,  1'b1, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b1, 1'b0, 16'd1};
        tbl[2]  = '{1'b1, 16'd10, 1'b0, 1'b1, 16'd8,   1'b1, 1'b0, 16'd1};
        tbl[3]  = '{1'b1, 16'd20, 1'b0, 1'b1, 16'd8,   1'b0, 1'b0, 16'd1};
        tbl[4]  = '{1'b1, 16'd30, 1'b0, 1'b1, 16'd8,   1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, 16'd30, 1'b1, 1'b1, 16'd18,  1'b1, 1'b0, 16'd2};
        tbl[6]  = '{1'b1, 16'd30, 1'b1, 1'b1, 16'd28,  1'b1, 1'b0, 16'd3};
        tbl[7]  = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b1, 1'b0, 16'd4};
        tbl[8]  = '{1'b1, 16'd5,  1'b0, 1'b1, 16'd3,   1'b1, 1'b0, 16'd4};
        tbl[9]  = '{1'b1, 16'd7,  1'b1, 1'b1, 16'd5,   1'b1, 1'b0, 16'd5};
        tbl[10] = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b1, 1'b0, 16'd6};
        tbl[11] = '{1'b1, 16'd1,  1'b1, 1'b1, uf_word, 1'b1, 1'b1, 16'd6};
        tbl[12] = '{1'b0, 16'd0,  1'b0, 1'b1, uf_word, 1'b1, 1'b1, 16'd6};
        tbl[13] = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b1, 1'b1, 16'd7};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        chk("ready_low_before_edge", 32'(in_ready), 32'd0);
        step(1'b0, 16'd0, 1'b0);
        chk("ready_first_edge", 32'(in_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_uf", i), 32'(underflow), 32'(tbl[i].e_uf));
            chk($sformatf("tbl%0d_count", i), 32'(out_count), 32'(tbl[i].e_count));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
        end

        // Reset pulse while FULL: outputs clear immediately, nothing stale after.
        step(1'b1, 16'd40, 1'b0);
        step(1'b1, 16'd50, 1'b0);
        chk("full_before_reset", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_count", 32'(out_count), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chk("async_underflow", 32'(underflow), 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_low_after_pulse", 32'(in_ready), 32'd0);
        step(1'b0, 16'd0, 1'b1);
        chk("ready_after_pulse", 32'(in_ready), 32'd1);
        chk("no_stale_word", 32'(out_valid), 32'd0);
        step(1'b0, 16'd0, 1'b1);

        // Random traffic against the queue model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
        end

        // Continuous streaming until the transfer counter wraps.
        do_reset();
        step(1'b1, 16'd100, 1'b1);
        for (int i = 0; i < 65536; i++) step(1'b1, 16'(i), 1'b1);
        chk("count_wrap", 32'(out_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
